// File: rtl/fifo_stream_reader_if.sv
// Read port of syn_FIFO plus the valid/ready output stream.
// master = reader side, slave = FIFO + downstream consumer side.
interface fifo_stream_reader_if #(
  parameter int d_width = 8
);
  logic               isEmpty;
  logic               r_en;
  logic [d_width-1:0] r_data;
  logic               m_valid;
  logic               m_ready;
  logic [d_width-1:0] m_data;

  modport master (
    input  isEmpty,
    input  r_data,
    input  m_ready,
    output r_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output isEmpty,
    output r_data,
    output m_ready,
    input  r_en,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains syn_FIFO into a valid/ready stream via a head+skid buffer.
// FIFO_RD_CNT_EN adds the rd_count delivered-word counter.
module fifo_stream_reader #(
  parameter int d_width = 8
`ifdef FIFO_RD_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic clk,
  input  logic n_rst,
  fifo_stream_reader_if.master bus
`ifdef FIFO_RD_CNT_EN
  , output logic [CNT_W-1:0] rd_count
`endif
);

  logic               inflight;
  logic [1:0]         occ;
  logic [d_width-1:0] head;
  logic [d_width-1:0] skid;
  logic               pop;
  logic [2:0]         need;
  logic               r_en;

  assign pop  = (occ != 2'd0) && bus.m_ready;

  // Credit: buffered + outstanding words after this edge must fit in 2
  assign need = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign r_en = n_rst && !bus.isEmpty && (need < 3'd2);

  assign bus.r_en    = r_en;
  assign bus.m_valid = (occ != 2'd0);
  assign bus.m_data  = head;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      inflight <= 1'b0;
      occ      <= 2'd0;
      head     <= '0;
      skid     <= '0;
    end else begin
      inflight <= r_en;
      unique case (1'b1)
        inflight && (occ == 2'd0 ||
                     (occ == 2'd1 && pop)): begin
          head <= bus.r_data;
          occ  <= 2'd1;
        end
        inflight && occ == 2'd1 && !pop: begin
          skid <= bus.r_data;
          occ  <= 2'd2;
        end
        inflight && occ == 2'd2 && pop: begin
          head <= skid;
          skid <= bus.r_data;
        end
        !inflight && occ == 2'd2 && pop: begin
          head <= skid;
          occ  <= 2'd1;
        end
        !inflight && occ == 2'd1 && pop: begin
          occ <= 2'd0;
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_count <= '0;
    end else if (pop) begin
      rd_count <= rd_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader against a behavioural 8-deep FIFO.
// Build with FIFO_RD_CNT_EN defined to also cover rd_count (CNT_W=4).
module tb_fifo_stream_reader;

  logic clk;
  logic n_rst;
  logic w_en;
  logic [7:0] w_data;

  fifo_stream_reader_if #(.d_width(8)) bus ();

`ifdef FIFO_RD_CNT_EN
  logic [3:0] rd_count;
  fifo_stream_reader #(.d_width(8), .CNT_W(4)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus), .rd_count(rd_count)
  );
`else
  fifo_stream_reader #(.d_width(8)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [8];
  logic [2:0] wp;
  logic [2:0] rp;
  logic [3:0] cnt;
  logic [7:0] fifo_rdata;
  logic       full;

  assign full        = (cnt == 4'd8);
  assign bus.isEmpty = (cnt == 4'd0);
  assign bus.r_data  = fifo_rdata;

  logic [7:0] exp_q[$];
  logic [7:0] rx[$];
  int         pop_cyc[$];
  int         cyc_n;
  int         ren_cnt;
  int         sb_err;
  int         inv_err;

  int checks;
  int errors;

  // FIFO model, scoreboard and invariant monitor in one process
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt        <= 4'd0;
      wp         <= 3'd0;
      rp         <= 3'd0;
      fifo_rdata <= 8'd0;
      exp_q.delete();
    end else begin
      cyc_n = cyc_n + 1;
      if (bus.r_en) ren_cnt = ren_cnt + 1;
      if (bus.r_en && bus.isEmpty) inv_err = inv_err + 1;
      if (dut.occ > 2'd2) inv_err = inv_err + 1;
      if (bus.m_valid && bus.m_ready) begin
        rx.push_back(bus.m_data);
        pop_cyc.push_back(cyc_n);
        if (exp_q.size() == 0) sb_err = sb_err + 1;
        else if (exp_q.pop_front() !== bus.m_data) sb_err = sb_err + 1;
      end
      if (w_en && !full) begin
        mem[wp] <= w_data;
        wp      <= wp + 3'd1;
        exp_q.push_back(w_data);
      end
      if (bus.r_en) begin
        fifo_rdata <= mem[rp];
        rp         <= rp + 3'd1;
      end
      cnt <= cnt + {3'd0, w_en && !full} - {3'd0, bus.r_en};
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_words(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      w_en   = 1'b1;
      w_data = 8'(base + i);
    end
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic wait_rx(input int target, input string tag);
    int budget;
    budget = 200;
    while (rx.size() < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk(tag, 32'(rx.size() >= target), 32'd1);
  endtask

  initial begin
    int s;
    int r0;
    int budget;
    int sent;
    checks  = 0;
    errors  = 0;
    cyc_n   = 0;
    ren_cnt = 0;
    sb_err  = 0;
    inv_err = 0;
    n_rst   = 1'b0;
    w_en    = 1'b0;
    w_data  = 8'd0;
    bus.m_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_ren", 32'(bus.r_en), 32'd0);
    chk("rst_data", 32'(bus.m_data), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // Single word: r_en in N, m_valid in N+2
    @(negedge clk);
    w_en   = 1'b1;
    w_data = 8'hA5;
    @(negedge clk);
    w_en = 1'b0;
    #1;
    chk("single_ren_N", 32'(bus.r_en), 32'd1);
    chk("single_valid_N", 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("single_ren_N1", 32'(bus.r_en), 32'd0);
    chk("single_valid_N1", 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("single_valid_N2", 32'(bus.m_valid), 32'd1);
    chk("single_data_N2", 32'(bus.m_data), 32'hA5);
    @(negedge clk);
    #1;
    chk("single_valid_N3", 32'(bus.m_valid), 32'd0);

    // Burst of 8 with sink always ready
    s = rx.size();
    write_words(8, 0);
    wait_rx(s + 8, "burst_timeout");
    for (int i = 0; i < 8; i++)
      chk($sformatf("burst_d%0d", i), 32'(rx[s + i]), 32'(i));
    chk("burst_gapless", 32'(pop_cyc[s + 7] - pop_cyc[s]), 32'd7);

    // Backpressure: exactly two reads, head held
    bus.m_ready = 1'b0;
    r0 = ren_cnt;
    s  = rx.size();
    write_words(8, 0);
    repeat (6) @(negedge clk);
    #1;
    chk("bp_reads", 32'(ren_cnt - r0), 32'd2);
    chk("bp_valid", 32'(bus.m_valid), 32'd1);
    chk("bp_data", 32'(bus.m_data), 32'd0);
    chk("bp_ren_low", 32'(bus.r_en), 32'd0);
    @(negedge clk);
    #1;
    chk("bp_data_hold", 32'(bus.m_data), 32'd0);
    bus.m_ready = 1'b1;
    wait_rx(s + 8, "bp_timeout");
    repeat (5) @(negedge clk);
    chk("bp_count", 32'(rx.size() - s), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("bp_d%0d", i), 32'(rx[s + i]), 32'(i));

    // Asynchronous reset mid-stream
    bus.m_ready = 1'b0;
    write_words(3, 8'h40);
    repeat (4) @(negedge clk);
    #1;
    chk("mid_valid_pre", 32'(bus.m_valid), 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_valid", 32'(bus.m_valid), 32'd0);
    chk("mid_ren", 32'(bus.r_en), 32'd0);
    chk("mid_data", 32'(bus.m_data), 32'd0);
`ifdef FIFO_RD_CNT_EN
    chk("mid_rdcnt", 32'(rd_count), 32'd0);
`endif
    @(negedge clk);
    n_rst = 1'b1;
    bus.m_ready = 1'b1;

    // 18 words after reset (counter wraps at CNT_W=4)
    s = rx.size();
    write_words(18, 8'h10);
    wait_rx(s + 18, "w18_timeout");
    repeat (3) @(negedge clk);
    chk("w18_first", 32'(rx[s]), 32'h10);
    chk("w18_last", 32'(rx[s + 17]), 32'h21);
`ifdef FIFO_RD_CNT_EN
    chk("w18_rdcnt", 32'(rd_count), 32'd2);
`endif

    // Random writes and random ready, 1000 words
    s      = rx.size();
    sent   = 0;
    budget = 20000;
    while (rx.size() < s + 1000 && budget > 0) begin
      @(negedge clk);
      w_en   = !full && sent < 1000 && ($urandom % 2 == 0);
      w_data = 8'($urandom);
      if (w_en) sent++;
      bus.m_ready = ($urandom % 2 == 0);
      budget--;
    end
    @(negedge clk);
    w_en = 1'b0;
    chk("rand_received", 32'(rx.size() - s), 32'd1000);
    chk("rand_scoreboard", 32'(sb_err), 32'd0);
    chk("rand_invariants", 32'(inv_err), 32'd0);
`ifdef FIFO_RD_CNT_EN
    chk("rand_rdcnt", 32'(rd_count), 32'((18 + 1000) % 16));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
